// File: rtl/l2_bus_arbiter.sv
// Two-core arbiter in front of the L2 bus: grants one L1 request at a time, sequences L2 miss fills from dmem.
// Optional ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise core0 has fixed priority.
module l2_bus_arbiter #(
  parameter int MISS_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core0_req,
  input  logic        core1_req,
  input  logic [6:0]  core0_opcode,
  input  logic [6:0]  core1_opcode,
  input  logic [31:0] core0_addr,
  input  logic [31:0] core1_addr,
  input  logic [31:0] core0_wdata,
  input  logic [31:0] core1_wdata,
  output logic        core0_ack,
  output logic        core1_ack,
  output logic [31:0] core0_rdata,
  output logic [31:0] core1_rdata,
  output logic [1:0]  grant,
  output logic [6:0]  l2_opcode_out,
  output logic [31:0] l2_address_out,
  output logic [31:0] l2_data_out,
  input  logic [31:0] l2_data_in,
  input  logic [1:0]  l2_hit_in,
  output logic        dmem_rd_en,
  output logic [31:0] dmem_addr_out,
  input  logic [31:0] dmem_data_in
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    MISS  = 3'd2,
    FILL  = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [6:0] OP_LOAD       = 7'b0000011;
  localparam logic [1:0] L2_HIT        = 2'b10;
  localparam logic [1:0] L2_MISS       = 2'b01;
  localparam logic [3:0] MISS_CNT_INIT = 4'(MISS_LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic        owner;      // 0 = core0, 1 = core1
  logic        win;
  logic        any_req;
  logic [6:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  miss_cnt;
  logic        is_load;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_grant; // 1 = core1 was served last
`endif

  assign any_req = core0_req | core1_req;
  assign is_load = (op_q == OP_LOAD);

  // Winner selection, only meaningful while IDLE with a request pending
  always_comb begin
    win = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (core0_req && core1_req)
      win = ~last_grant;
    else
      win = ~core0_req;
`else
    win = ~core0_req;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        if (is_load && (l2_hit_in == L2_MISS))
          state_nxt = MISS;
        else
          state_nxt = RESP;
      end
      MISS: begin
        if (miss_cnt == 4'd0)
          state_nxt = FILL;
      end
      FILL:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus and core-side outputs decode from the state and the request latch only
  always_comb begin
    grant          = 2'b00;
    l2_opcode_out  = 7'b0;
    l2_address_out = 32'b0;
    l2_data_out    = 32'b0;
    core0_ack      = 1'b0;
    core1_ack      = 1'b0;
    core0_rdata    = 32'b0;
    core1_rdata    = 32'b0;
    if (state != IDLE)
      grant = owner ? 2'b10 : 2'b01;
    case (state)
      ISSUE, FILL: begin
        l2_opcode_out  = op_q;
        l2_address_out = addr_q;
        l2_data_out    = wdata_q;
      end
      RESP: begin
        if (owner) begin
          core1_ack   = 1'b1;
          core1_rdata = rdata_q;
        end else begin
          core0_ack   = 1'b1;
          core0_rdata = rdata_q;
        end
      end
      default: ;
    endcase
  end

  // Request latch: data fields are not reset, they never reach the bus outside ISSUE/FILL
  always_ff @(posedge clk) begin
    if ((state == IDLE) && any_req) begin
      op_q    <= win ? core1_opcode : core0_opcode;
      addr_q  <= win ? core1_addr   : core0_addr;
      wdata_q <= win ? core1_wdata  : core0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= 1'b0;
      rdata_q       <= 32'b0;
      miss_cnt      <= 4'd0;
      dmem_rd_en    <= 1'b0;
      dmem_addr_out <= 32'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant    <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req)
            owner <= win;
        end
        ISSUE: begin
          rdata_q <= 32'b0;
          if (is_load && (l2_hit_in == L2_HIT)) begin
            rdata_q <= l2_data_in;
          end else if (is_load && (l2_hit_in == L2_MISS)) begin
            miss_cnt      <= MISS_CNT_INIT;
            dmem_rd_en    <= 1'b1;
            dmem_addr_out <= addr_q;
          end
        end
        MISS: begin
          if (miss_cnt != 4'd0)
            miss_cnt <= miss_cnt - 4'd1;
        end
        FILL: begin
          rdata_q       <= dmem_data_in;
          dmem_rd_en    <= 1'b0;
          dmem_addr_out <= 32'b0;
        end
        RESP: begin
`ifdef ARB_ROUND_ROBIN_EN
          last_grant <= owner;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Directed bench for l2_bus_arbiter: hit, miss, store, other opcode, contention and reset-during-miss.
module tb_l2_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core0_req, core1_req;
  logic [6:0]  core0_opcode, core1_opcode;
  logic [31:0] core0_addr, core1_addr, core0_wdata, core1_wdata;
  logic        core0_ack, core1_ack;
  logic [31:0] core0_rdata, core1_rdata;
  logic [1:0]  grant;
  logic [6:0]  l2_opcode_out;
  logic [31:0] l2_address_out, l2_data_out, l2_data_in;
  logic [1:0]  l2_hit_in;
  logic        dmem_rd_en;
  logic [31:0] dmem_addr_out, dmem_data_in;

  int errors = 0;
  int checks = 0;

  l2_bus_arbiter #(.MISS_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .core0_req(core0_req), .core1_req(core1_req),
    .core0_opcode(core0_opcode), .core1_opcode(core1_opcode),
    .core0_addr(core0_addr), .core1_addr(core1_addr),
    .core0_wdata(core0_wdata), .core1_wdata(core1_wdata),
    .core0_ack(core0_ack), .core1_ack(core1_ack),
    .core0_rdata(core0_rdata), .core1_rdata(core1_rdata),
    .grant(grant),
    .l2_opcode_out(l2_opcode_out), .l2_address_out(l2_address_out),
    .l2_data_out(l2_data_out), .l2_data_in(l2_data_in), .l2_hit_in(l2_hit_in),
    .dmem_rd_en(dmem_rd_en), .dmem_addr_out(dmem_addr_out), .dmem_data_in(dmem_data_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  initial begin
    reset = 1'b1;
    core0_req = 1'b0; core1_req = 1'b0;
    core0_opcode = 7'b0; core1_opcode = 7'b0;
    core0_addr = 32'b0; core1_addr = 32'b0;
    core0_wdata = 32'b0; core1_wdata = 32'b0;
    l2_data_in = 32'b0; l2_hit_in = 2'b00; dmem_data_in = 32'b0;
    tick(); tick();

    // Reset state
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ack0", 32'(core0_ack), 32'h0);
    check("rst_ack1", 32'(core1_ack), 32'h0);
    check("rst_l2op", 32'(l2_opcode_out), 32'h0);
    check("rst_l2addr", l2_address_out, 32'h0);
    check("rst_dmem_en", 32'(dmem_rd_en), 32'h0);
    check("rst_dmem_addr", dmem_addr_out, 32'h0);
    reset = 1'b0;
    tick();

    // Core0 load hit
    core0_req = 1'b1; core0_opcode = LD; core0_addr = 32'h0000_0800;
    l2_hit_in = 2'b10; l2_data_in = 32'h0000_0200;
    check("hit_t_grant", 32'(grant), 32'h0);
    tick();
    check("hit_t1_grant", 32'(grant), 32'h1);
    check("hit_t1_op", 32'(l2_opcode_out), 32'(LD));
    check("hit_t1_addr", l2_address_out, 32'h800);
    check("hit_t1_ack", 32'(core0_ack), 32'h0);
    tick();
    check("hit_t2_ack", 32'(core0_ack), 32'h1);
    check("hit_t2_rdata", core0_rdata, 32'h200);
    check("hit_t2_op", 32'(l2_opcode_out), 32'h0);
    core0_req = 1'b0;
    tick();
    check("hit_t3_ack", 32'(core0_ack), 32'h0);
    check("hit_t3_grant", 32'(grant), 32'h0);

    // Core0 load miss, latency 2
    core0_req = 1'b1; core0_addr = 32'h0000_0900;
    l2_hit_in = 2'b01; dmem_data_in = 32'hDEAD_BEEF;
    tick();
    check("miss_t1_op", 32'(l2_opcode_out), 32'(LD));
    check("miss_t1_den", 32'(dmem_rd_en), 32'h0);
    tick();
    check("miss_t2_den", 32'(dmem_rd_en), 32'h1);
    check("miss_t2_daddr", dmem_addr_out, 32'h900);
    check("miss_t2_op", 32'(l2_opcode_out), 32'h0);
    tick();
    check("miss_t3_den", 32'(dmem_rd_en), 32'h1);
    check("miss_t3_op", 32'(l2_opcode_out), 32'h0);
    check("miss_t3_ack", 32'(core0_ack), 32'h0);
    tick();
    check("miss_t4_den", 32'(dmem_rd_en), 32'h1);
    check("miss_t4_op", 32'(l2_opcode_out), 32'(LD));
    check("miss_t4_addr", l2_address_out, 32'h900);
    check("miss_t4_ack", 32'(core0_ack), 32'h0);
    tick();
    check("miss_t5_ack", 32'(core0_ack), 32'h1);
    check("miss_t5_rdata", core0_rdata, 32'hDEAD_BEEF);
    check("miss_t5_den", 32'(dmem_rd_en), 32'h0);
    core0_req = 1'b0;
    tick();

    // Core1 store; L2 status shows a miss to confirm stores never start a fetch
    core1_req = 1'b1; core1_opcode = ST; core1_addr = 32'h0000_0804; core1_wdata = 32'h1234_5678;
    l2_hit_in = 2'b01; l2_data_in = 32'h0000_0200;
    tick();
    check("st_t1_grant", 32'(grant), 32'h2);
    check("st_t1_op", 32'(l2_opcode_out), 32'(ST));
    check("st_t1_addr", l2_address_out, 32'h804);
    check("st_t1_data", l2_data_out, 32'h1234_5678);
    tick();
    check("st_t2_ack1", 32'(core1_ack), 32'h1);
    check("st_t2_ack0", 32'(core0_ack), 32'h0);
    check("st_t2_rdata", core1_rdata, 32'h0);
    check("st_t2_den", 32'(dmem_rd_en), 32'h0);
    core1_req = 1'b0;
    tick();
    check("st_t3_den", 32'(dmem_rd_en), 32'h0);

    // Other opcode on a hit returns zero data
    core0_req = 1'b1; core0_opcode = 7'b0110011; core0_addr = 32'h0000_0A00;
    l2_hit_in = 2'b10; l2_data_in = 32'h0000_0200;
    tick();
    check("oth_t1_op", 32'(l2_opcode_out), 32'h33);
    tick();
    check("oth_t2_ack", 32'(core0_ack), 32'h1);
    check("oth_t2_rdata", core0_rdata, 32'h0);
    core0_req = 1'b0;
    tick();

    // Contention: both cores hold load-hit requests; last served was core0
    core0_opcode = LD; core1_opcode = LD;
    core0_addr = 32'h0000_0100; core1_addr = 32'h0000_0104;
    l2_hit_in = 2'b10; l2_data_in = 32'h0000_0055;
    core0_req = 1'b1; core1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_g;
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      tick();
      check($sformatf("cont%0d_grant", i), 32'(grant), 32'(exp_g));
      tick();
      check($sformatf("cont%0d_ack0", i), 32'(core0_ack), 32'(exp_g[0]));
      check($sformatf("cont%0d_ack1", i), 32'(core1_ack), 32'(exp_g[1]));
      if (i == 3) begin
        core0_req = 1'b0; core1_req = 1'b0;
      end
      tick();
      check($sformatf("cont%0d_idle", i), 32'(grant), 32'h0);
    end

    // Reset during MISS, then the held request completes from scratch
    core0_req = 1'b1; core0_opcode = LD; core0_addr = 32'h0000_0C00;
    l2_hit_in = 2'b01; dmem_data_in = 32'hCAFE_F00D;
    tick(); tick(); tick();
    check("rm_t3_den", 32'(dmem_rd_en), 32'h1);
    reset = 1'b1;
    tick();
    check("rm_t4_grant", 32'(grant), 32'h0);
    check("rm_t4_den", 32'(dmem_rd_en), 32'h0);
    check("rm_t4_ack", 32'(core0_ack), 32'h0);
    reset = 1'b0;
    tick();
    check("rm_t5_grant", 32'(grant), 32'h1);
    for (int k = 6; k <= 8; k++) begin
      tick();
      check($sformatf("rm_t%0d_ack", k), 32'(core0_ack), 32'h0);
    end
    tick();
    check("rm_t9_ack", 32'(core0_ack), 32'h1);
    check("rm_t9_rdata", core0_rdata, 32'hCAFE_F00D);
    core0_req = 1'b0;
    tick();
    check("rm_t10_grant", 32'(grant), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
